// File: rtl/frame_scanout_pkg.sv
// Shared colour definitions and the layer compositing rule for the scan-out path.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package frame_scanout_pkg;

    localparam int COLOR_WIDTH = 8;

    // COLOR_NONE marks a transparent pixel in any layer.
    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 8'h00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 8'h01;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 8'hff;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 8'he0;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 8'h1c;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 8'h03;

    // Shown where neither layer draws anything; must differ from COLOR_NONE.
    localparam logic [COLOR_WIDTH-1:0] COLOR_BG    = COLOR_BLACK;

    // Cursor sits on top of the canvas, the background sits under both.
    function automatic logic [COLOR_WIDTH-1:0] composite_pixel(
        input logic [COLOR_WIDTH-1:0] cursor_c,
        input logic [COLOR_WIDTH-1:0] canvas_c,
        input logic [COLOR_WIDTH-1:0] bg_c
    );
        logic [COLOR_WIDTH-1:0] result;
        result = bg_c;
        if (cursor_c != COLOR_NONE) begin
            result = cursor_c;
        end else if (canvas_c != COLOR_NONE) begin
            result = canvas_c;
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_scanout_raster_counter.sv
// Raster-order (x,y) fetch coordinate generator; x runs fastest.
// Latency: coordinate updates on the edge after clear/advance.
// Backpressure: advances only when told; saturates on the last pixel so it never leaves the frame.
module raster_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      advance,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      last
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    logic x_wrap;

    // Row end and frame end detection.
    always_comb begin
        x_wrap = (x == X_MAX);
        last   = x_wrap && (y == Y_MAX);
    end

    // Step through the frame; hold on the final pixel so indices stay in range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance && !last) begin
            if (x_wrap) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Composites cursor over canvas over background and streams one frame of (x,y)-tagged pixels.
// Latency: start sampled at edge N gives the (0,0) pixel valid after edge N+1; 1 pixel/cycle sustained.
// Backpressure: valid/ready; a stalled pixel holds colour/x/y/frame_first stable until accepted.
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int                     WIDTH    = 640,
    parameter int                     HEIGHT   = 480,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR = COLOR_BG
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [COLOR_WIDTH-1:0]    cursor_frame [WIDTH][HEIGHT],
    input  logic [COLOR_WIDTH-1:0]    canvas_frame [WIDTH][HEIGHT],
    input  logic                      pixel_ready,
    output logic                      pixel_valid,
    output logic [COLOR_WIDTH-1:0]    pixel_color,
    output logic [$clog2(WIDTH)-1:0]  pixel_x,
    output logic [$clog2(HEIGHT)-1:0] pixel_y,
    output logic                      frame_first,
    output logic                      busy,
    output logic                      done
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_SCAN = 1'b1;

    logic [0:0]                state;
    logic                      fetch_left;   // a coordinate is still waiting to be loaded this frame
    logic                      out_last;     // the pixel in the output register is the frame's last
    logic [$clog2(WIDTH)-1:0]  fetch_x;
    logic [$clog2(HEIGHT)-1:0] fetch_y;
    logic                      fetch_last;
    logic [COLOR_WIDTH-1:0]    fetch_color;
    logic                      start_go;
    logic                      accept;
    logic                      load;

    // Handshake and control decode. Start is refused on the done cycle so a
    // clean IDLE cycle always separates two frames.
    always_comb begin
        start_go = (state == STATE_IDLE) && start && !done;
        accept   = pixel_valid && pixel_ready;
        load     = (state == STATE_SCAN) && fetch_left && (!pixel_valid || pixel_ready);
        busy     = (state == STATE_SCAN);
    end

    // Layers are read live at the fetch coordinate; writes landing mid-frame show up if not yet fetched.
    always_comb begin
        fetch_color = composite_pixel(cursor_frame[fetch_x][fetch_y],
                                      canvas_frame[fetch_x][fetch_y],
                                      BG_COLOR);
    end

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_go),
        .advance (load),
        .x       (fetch_x),
        .y       (fetch_y),
        .last    (fetch_last)
    );

    // Frame FSM: leave SCAN once the last pixel has actually been handed downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else begin
            case (state)
                STATE_IDLE: if (start_go) state <= STATE_SCAN;
                STATE_SCAN: if (accept && out_last) state <= STATE_IDLE;
                default:    state <= STATE_IDLE;
            endcase
        end
    end

    // Track whether any coordinate remains to be loaded in the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_left <= 1'b0;
        end else if (start_go) begin
            fetch_left <= 1'b1;
        end else if (load && fetch_last) begin
            fetch_left <= 1'b0;
        end
    end

    // One-cycle completion pulse following acceptance of the final pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == STATE_SCAN) && accept && out_last;
        end
    end

    // Output register: refill whenever the slot is empty or being drained, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_color <= COLOR_NONE;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_first <= 1'b0;
            out_last    <= 1'b0;
        end else if (load) begin
            pixel_valid <= 1'b1;
            pixel_color <= fetch_color;
            pixel_x     <= fetch_x;
            pixel_y     <= fetch_y;
            frame_first <= (fetch_x == '0) && (fetch_y == '0);
            out_last    <= fetch_last;
        end else if (accept) begin
            pixel_valid <= 1'b0;
            frame_first <= 1'b0;
            out_last    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout on a 4x3 frame with directed and randomized frames.
// Latency: not applicable.
// Backpressure: drives pixel_ready with fixed, patterned and random sequences.
module tb_frame_scanout;
    import frame_scanout_pkg::*;

    localparam int W            = 4;
    localparam int H            = 3;
    localparam int N            = W * H;
    localparam int CLOCK_PERIOD = 100;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   pixel_ready;
    logic [COLOR_WIDTH-1:0] cur [W][H];
    logic [COLOR_WIDTH-1:0] can [W][H];
    logic                   pixel_valid;
    logic [COLOR_WIDTH-1:0] pixel_color;
    logic [1:0]             pixel_x;
    logic [1:0]             pixel_y;
    logic                   frame_first;
    logic                   busy;
    logic                   done;

    int vectors     = 0;
    int miscompares = 0;

    frame_scanout #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .BG_COLOR (COLOR_BG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cursor_frame (cur),
        .canvas_frame (can),
        .pixel_ready  (pixel_ready),
        .pixel_valid  (pixel_valid),
        .pixel_color  (pixel_color),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .frame_first  (frame_first),
        .busy         (busy),
        .done         (done)
    );

    always #(CLOCK_PERIOD / 2) clk = ~clk;

    initial begin
        #(CLOCK_PERIOD * 20000);
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: topmost non-transparent layer wins, background if none.
    function automatic logic [COLOR_WIDTH-1:0] model_color(input int x, input int y);
        if (cur[x][y] != COLOR_NONE) return cur[x][y];
        if (can[x][y] != COLOR_NONE) return can[x][y];
        return COLOR_BG;
    endfunction

    function automatic logic [COLOR_WIDTH-1:0] rand_color(input int pct_none);
        if ($urandom_range(0, 99) < pct_none) return COLOR_NONE;
        return COLOR_WIDTH'($urandom_range(1, 255));
    endfunction

    task automatic fill_layers(input logic [COLOR_WIDTH-1:0] cur_c, input logic [COLOR_WIDTH-1:0] can_c);
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                cur[x][y] = cur_c;
                can[x][y] = can_c;
            end
        end
    endtask

    task automatic fill_random(input int cur_none, input int can_none);
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                cur[x][y] = rand_color(cur_none);
                can[x][y] = rand_color(can_none);
            end
        end
    endtask

    // Runs one frame from a start pulse; called at 10 time units after a posedge.
    // mode: 0 ready always high, 1 ready pattern 1,0,0,..., 2 random ready.
    task automatic run_frame(input int mode, input int restart_at, input int reset_at,
                             input int write_at, input bit start_on_done);
        int                     k         = 0;
        int                     cyc       = 0;
        int                     first_cyc = -1;
        int                     last_cyc  = -1;
        bit                     hold      = 1'b0;
        bit                     restarted = 1'b0;
        bit                     wrote     = 1'b0;
        logic [COLOR_WIDTH-1:0] h_c;
        logic [1:0]             h_x;
        logic [1:0]             h_y;
        logic                   h_f;
        logic [COLOR_WIDTH-1:0] wc = COLOR_NONE;

        start = 1'b1;
        @(posedge clk); #10;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_before_first", pixel_valid, 0);
        @(posedge clk); #10;
        check("first_pixel_latency", pixel_valid, 1);
        cyc = 1;

        while (k < N && cyc < 300) begin
            if (reset_at >= 0 && k == reset_at) begin
                reset = 1'b1;
                #1;
                check("reset_mid_valid", pixel_valid, 0);
                check("reset_mid_busy", busy, 0);
                @(posedge clk); #10;
                reset = 1'b0;
                repeat (4) begin
                    check("reset_no_done", done, 0);
                    check("reset_stays_idle", busy, 0);
                    @(posedge clk); #10;
                end
                return;
            end

            check("busy_in_scan", busy, 1);
            check("no_early_done", done, 0);
            if (hold) begin
                check("hold_valid", pixel_valid, 1);
                check("hold_color", pixel_color, h_c);
                check("hold_x", pixel_x, h_x);
                check("hold_y", pixel_y, h_y);
                check("hold_first", frame_first, h_f);
            end

            if (write_at >= 0 && k == write_at && !wrote) begin
                wc        = (cur[3][2] == 8'ha5) ? 8'h5a : 8'ha5;
                cur[3][2] = wc;
                wrote     = 1'b1;
            end

            case (mode)
                0:       pixel_ready = 1'b1;
                1:       pixel_ready = ((cyc - 1) % 3) == 0;
                default: pixel_ready = 1'($urandom_range(0, 1));
            endcase

            hold = 1'b0;
            if (pixel_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("frame_first", frame_first, k == 0);
                if (pixel_ready) begin
                    check("pixel_x", pixel_x, k % W);
                    check("pixel_y", pixel_y, k / W);
                    check("pixel_color", pixel_color, model_color(k % W, k / W));
                    if (wrote && k == N - 1) check("live_write_color", pixel_color, wc);
                    k++;
                    last_cyc = cyc;
                end else begin
                    hold = 1'b1;
                    h_c  = pixel_color;
                    h_x  = pixel_x;
                    h_y  = pixel_y;
                    h_f  = frame_first;
                end
            end

            if (restart_at >= 0 && k == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end

            @(posedge clk); #10;
            start = 1'b0;
            cyc++;
        end

        check("transfer_count", k, N);
        check("done_pulse", done, 1);
        check("busy_after_last", busy, 0);
        check("valid_after_last", pixel_valid, 0);
        if (mode == 0) check("consecutive_cycles", last_cyc - first_cyc + 1, N);
        if (start_on_done) start = 1'b1;
        pixel_ready = 1'b1;
        @(posedge clk); #10;
        start = 1'b0;
        check("done_single_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("no_pixel_when_idle", pixel_valid, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pixel_ready = 1'b0;
        fill_layers(COLOR_NONE, COLOR_NONE);
        #10;
        check("reset_valid", pixel_valid, 0);
        check("reset_color", pixel_color, COLOR_NONE);
        check("reset_x", pixel_x, 0);
        check("reset_y", pixel_y, 0);
        check("reset_first", frame_first, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge clk); #10;
        reset = 1'b0;
        @(posedge clk); #10;

        // Both layers transparent: background everywhere, full rate.
        run_frame(0, -1, -1, -1, 1'b0);

        // Blue canvas with a two-pixel cursor.
        fill_layers(COLOR_NONE, COLOR_BLUE);
        cur[1][1] = COLOR_RED;
        cur[2][1] = COLOR_RED;
        run_frame(0, -1, -1, -1, 1'b0);

        // Ready pattern 1,0,0 repeating.
        fill_random(50, 30);
        run_frame(1, -1, -1, -1, 1'b0);

        // Start while busy and on the done cycle, then a fresh frame.
        run_frame(0, 5, -1, -1, 1'b1);
        run_frame(0, -1, -1, -1, 1'b0);

        // Reset at pixel 7, then restart from (0,0).
        run_frame(0, -1, 7, -1, 1'b0);
        run_frame(0, -1, -1, -1, 1'b0);

        // Cursor write at (3,2) before it is fetched.
        fill_random(40, 40);
        run_frame(2, -1, -1, 5, 1'b0);

        // Random layers with random backpressure.
        repeat (4) begin
            fill_random(30, 30);
            run_frame(2, -1, -1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
